sprite_rom_fetch_arbiter: RTL
=============================

// Module: sprite_rom_fetch_arbiter
// PURPOSE
//  Shares the single-port 4096x8 sprite ROM read port between NUM_REQ burst requesters.
//  Requesters are the sprite line-buffer fill engines and the score-digit fetcher.
//  Each accepted request is a burst of consecutive bytes, which the block sequences onto the ROM.
//  Returned bytes are tagged with the requester id and a last-byte flag.
//  Sits between the fill engines and the ROM s1 port; it is the only master of that port.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  ADDR_W   12  ROM address width (4096 bytes)
//  DATA_W   8   ROM data width
//  LEN_W    6   burst length field width; burst bytes = req_len+1 (1..2**LEN_W)
//  ID_W     $clog2(NUM_REQ)  rsp_id width (derived, not overridden)
// PORTS
//  clk           in   1               system clock, single domain
//  reset         in   1               synchronous, active-high
//  req_valid     in   NUM_REQ         per-requester request pending; held until its req_ready
//  req_addr      in   NUM_REQ*ADDR_W  per-requester burst base address, slice i = requester i
//  req_len       in   NUM_REQ*LEN_W   per-requester burst length minus one
//  req_ready     out  NUM_REQ         one-cycle accept pulse; at most one bit set
//  rsp_valid     out  1               rsp_data carries a ROM byte this cycle
//  rsp_data      out  DATA_W          ROM byte; forced to 0 when rsp_valid=0
//  rsp_id        out  ID_W            requester owning rsp_data
//  rsp_last      out  1               final byte of the burst (with rsp_valid)
//  busy          out  1               state==BURST or a response is still in flight
//  rom_address   out  ADDR_W          to ROM address
//  rom_clken     out  1               to ROM clken; 1 only in BURST
//  rom_write     out  1               tied 0; the block never writes the ROM
//  rom_readdata  in   DATA_W          from ROM readdata (valid the cycle after address is sampled)
// BEHAVIOUR
//  - Reset (sync, any state): state=IDLE, counters 0, rr_ptr=NUM_REQ-1 (requester 0 wins first).
//    All outputs are 0. In-flight response is dropped: rsp_valid=0 the cycle after reset is sampled.
//  - FSM IDLE: if any req_valid, pick winner g by round-robin starting at rr_ptr+1 (mod NUM_REQ).
//    Latch addr/len of g, rr_ptr<=g, go to BURST. No request: stay IDLE, rom_clken=0.
//  - FSM BURST: cycle k (k=0..len) drives rom_address=base+k mod 2**ADDR_W with rom_clken=1.
//    req_ready[g]=1 only in BURST cycle k=0; the requester deasserts req_valid at that edge.
//    After k==len issues, return to IDLE. Arbitration cycle means 1 dead ROM cycle between bursts.
//  - Response pipeline: rsp_valid/rsp_id/rsp_last are registered copies of issue/g/(k==len).
//    rsp_data=rom_readdata gated by rsp_valid. Fixed latency: byte k appears 1 cycle after issue.
//  - No backpressure: consumers must accept every rsp_valid beat.
//  - Address arithmetic: ADDR_W-bit add, wraps 0xFFF->0x000 silently. Counter is LEN_W+1 bits.
//  - req_valid changes of non-granted requesters during BURST are ignored until next IDLE.
//  - req_addr/req_len are sampled only in the IDLE grant cycle; later changes have no effect.
//  - Simultaneous requests: exactly one grant; others wait, no request is lost or duplicated.
// CONFIGURATION
//  SPRITE_ROM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr unused.
//    Requester 0 (display fetcher) may starve the others.
//  Not defined (default): round-robin as above; max wait per requester is (NUM_REQ-1) bursts.
// TESTING
//  1 req0 addr=0x010 len=3 alone -> req_ready[0] 1 cycle; rom_address 010,011,012,013 consecutive;
//    rsp_valid 4 beats id=0 data=mem[0x010..0x013], rsp_last on 4th only.
//  2 req2 addr=0xFFE len=3 -> addresses FFE,FFF,000,001; data mem[FFE],mem[FFF],mem[0],mem[1].
//  3 req0..3 valid together, len=0 each -> grants 0,1,2,3 in order, one IDLE cycle between.
//    Each has a single beat with rsp_last=1; with FIXED_PRIO_EN and req0 re-asserting, only 0 served.
//  4 req1 and req3 held valid continuously, len=1 -> grant order 1,3,1,3; never two req_ready bits.
//  5 req0 len=63 -> 64 beats; rsp_last only on beat 64; busy high throughout, low 1 cycle after.
//  6 reset asserted mid-burst (beat 5 of 64) -> next cycle all outputs 0, state IDLE.
//    Next grant goes to req0 if valid.

Source files
------------

// File: rtl/sprite_rom_fetch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_rom_fetch_arbiter
//  Description : Shares the single-port sprite ROM read port between NUM_REQ
//                burst requesters. A granted request becomes a burst of
//                consecutive ROM reads. Returned bytes carry the requester id
//                and a last-byte flag, and arrive one cycle after issue.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                req_valid/addr/len    - per-requester burst requests
//                req_ready             - one-cycle accept pulse (one-hot/zero)
//                rsp_valid/data/id/last- tagged ROM byte stream, no backpressure
//                busy                  - burst active or response in flight
//                rom_address/clken/write/readdata - ROM s1 port (read only)
//  Options     : define SPRITE_ROM_ARB_FIXED_PRIO_EN for fixed priority
//                (lowest index wins); default is round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_rom_fetch_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = 12,
    parameter  int DATA_W  = 8,
    parameter  int LEN_W   = 6,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      rsp_last,
    output logic                      busy,
    output logic [ADDR_W-1:0]         rom_address,
    output logic                      rom_clken,
    output logic                      rom_write,
    input  logic [DATA_W-1:0]         rom_readdata
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W:0]    r_cnt;      // one bit wider so a full 2**LEN_W burst counts cleanly
    logic [ID_W-1:0]   r_gnt;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_last;

    logic              w_any_req;
    logic [ID_W-1:0]   w_winner;
    logic              w_issue;
    logic              w_last_issue;

    assign w_any_req = |req_valid;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest requesting index is the last write.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_winner = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] r_rr_ptr;
    int              w_idx;
    logic            w_found;

    // Search starts one past the last winner; offset NUM_REQ revisits the
    // last winner itself, so a lone requester can be granted back-to-back.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = int'(r_rr_ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_winner = w_idx[ID_W-1:0];
                w_found  = 1'b1;
            end
        end
    end
`endif

    // Next-state and ROM-side outputs. The accept pulse is raised in the
    // first burst cycle, after the grant has been latched in IDLE.
    always_comb begin
        w_state_nxt  = r_state;
        w_issue      = 1'b0;
        w_last_issue = 1'b0;
        req_ready    = '0;
        rom_address  = '0;
        rom_clken    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                w_issue     = 1'b1;
                rom_clken   = 1'b1;
                rom_address = r_base + ADDR_W'(r_cnt);
                if (r_cnt == '0) begin
                    req_ready[r_gnt] = 1'b1;
                end
                if (r_cnt == {1'b0, r_len}) begin
                    w_last_issue = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_last  <= 1'b0;
`ifndef SPRITE_ROM_ARB_FIXED_PRIO_EN
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= w_issue;
            r_rsp_id    <= w_issue ? r_gnt : '0;
            r_rsp_last  <= w_last_issue;
            if (r_state == IDLE && w_any_req) begin
                r_base   <= req_addr[int'(w_winner) * ADDR_W +: ADDR_W];
                r_len    <= req_len[int'(w_winner) * LEN_W +: LEN_W];
                r_gnt    <= w_winner;
                r_cnt    <= '0;
`ifndef SPRITE_ROM_ARB_FIXED_PRIO_EN
                r_rr_ptr <= w_winner;
`endif
            end else if (w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ROM data is valid the cycle after the address was sampled, which is
    // exactly when the registered valid is high.
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_valid ? rom_readdata : '0;
    assign rsp_id    = r_rsp_id;
    assign rsp_last  = r_rsp_last;
    assign busy      = (r_state == BURST) | r_rsp_valid;
    assign rom_write = 1'b0;

endmodule
`default_nettype wire
